// File: rtl/data_memory_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_memory_lsu
// Brief    : Single-outstanding RV32I load/store unit in front of an on-chip
//            word RAM. Valid/ready request, configurable wait states,
//            byte-lane stores, sign/zero-extended loads, error flagging.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_lsu #(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_IDX_W  = $clog2(MEM_DEPTH);
    localparam int         c_AW     = c_IDX_W + 2;
    localparam logic [3:0] c_LAT    = 4'(LATENCY);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [c_AW-1:0]    r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [MEM_DEPTH];

    logic               w_access;
    logic               w_err;
    logic               w_wr_en;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_unused;

    // Address bits above the RAM range are deliberately ignored (wrap-around).
    assign w_unused  = &{1'b0, req_addr[31:c_AW]};

    assign req_ready = (r_state == c_S_IDLE);
    assign rsp_valid = (r_state == c_S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_idx     = r_addr[c_AW-1:2];
    assign w_access  = (r_state == c_S_WAIT) && (r_cnt == 4'd0);
    assign w_wr_en   = w_access && r_we && !w_err && !rst;

    // Flag illegal funct3 encodings and accesses not aligned to their size.
    always_comb begin
        if (r_we) begin
            w_err = r_funct3[2] | (r_funct3[1:0] == 2'b11);
        end else begin
            w_err = (r_funct3 == 3'd3) | (r_funct3 == 3'd6) | (r_funct3 == 3'd7);
        end
        if ((r_funct3[1:0] == 2'b01) && r_addr[0]) begin
            w_err = 1'b1;
        end
        if ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
    end

    // Store lane enables; data is replicated so every lane sees its bytes.
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Load lane selection and sign/zero extension.
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (r_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // Data RAM: byte-lane writes at the access edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Capture the request fields on accept; inputs are don't-care afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
        end else if ((r_state == c_S_IDLE) && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[c_AW-1:0];
            r_wdata  <= req_wdata;
        end
    end

    // Control FSM: IDLE -> WAIT (LATENCY wait states) -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (req_valid) begin
                        r_state <= c_S_WAIT;
                        r_cnt   <= c_LAT;
                    end
                end
                c_S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= c_S_RESP;
                        r_err   <= w_err;
                        r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                    end
                end
                c_S_RESP: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
